jk_excitation_sequencer: RTL and testbench
==========================================

Name: jk_excitation_sequencer

Overview:
- Drives one external jk_ff so that its q output follows a programmed bit pattern.
- For each target bit, computes J/K from the JK excitation table using the observed q_fb. It then lets the flip-flop clock the J/K values and checks the resulting q against the target.
- Sits on the stimulus side of a jk_ff: it writes J/K and reads back q. It serves as a self-checking pattern source for flip-flop and conversion blocks.

Parameters:
- WIDTH, 8, pattern length in bits; bit 0 is applied first.
- IDX_W, 3, width of bit_idx; must satisfy 2**IDX_W >= WIDTH.
- CNT_W, 4, width of err_cnt; the counter saturates.
- USE_TOGGLE, 0, selects how bit changes are encoded.
  - 1: changes (0->1, 1->0) are driven as j=1,k=1 (toggle).
  - 0: changes are driven as set/reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request; sampled only in IDLE
- pattern  input  WIDTH  target q sequence; latched on accepted start
- q_fb  input  1  q of the driven jk_ff
- j  output  1  registered J to the jk_ff
- k  output  1  registered K to the jk_ff
- busy  output  1  high from the cycle after start is accepted until done
- bit_idx  output  IDX_W  index of the bit currently being applied
- err_cnt  output  CNT_W  mismatches in the current or last run
- done  output  1  one-cycle pulse at the end of a run

Behaviour:
- Reset, applied at any clk edge with rst=1, overrides everything including a run in progress:
  - state=IDLE, j=0, k=0, busy=0, done=0, bit_idx=0, err_cnt=0, pattern register=0.
  - The run is abandoned and done is not issued.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, DRIVE, APPLY, CHECK, FIN.
- IDLE:
  - j=k=0, busy=0.
  - On start=1: latch pattern, bit_idx=0, err_cnt=0, busy=1, go to DRIVE.
  - err_cnt and bit_idx keep their last-run values until the next start.
- DRIVE: with t = pattern_reg[bit_idx] and c = q_fb, register j/k at this edge:
  - c=0, t=0: j=0, k=0.
  - c=0, t=1: j=1, k=0 if USE_TOGGLE=0; j=1, k=1 if USE_TOGGLE=1.
  - c=1, t=0: j=0, k=1 if USE_TOGGLE=0; j=1, k=1 if USE_TOGGLE=1.
  - c=1, t=1: j=0, k=0.
  - Next state: APPLY.
- APPLY:
  - j/k are held stable for the whole cycle; the jk_ff captures them at the closing edge.
  - At that same edge, j and k are cleared to 0.
  - Next state: CHECK.
- CHECK:
  - Compare q_fb with t. On mismatch, err_cnt += 1, saturating at 2**CNT_W-1 with no wrap.
  - If bit_idx == WIDTH-1: go to FIN. Otherwise bit_idx += 1 and go to DRIVE.
- FIN:
  - done=1 for exactly this cycle, busy=0 at the next edge, then return to IDLE.
  - bit_idx stays at WIDTH-1.
- Timing:
  - Each bit costs 3 cycles (DRIVE, APPLY, CHECK).
  - A run takes 3*WIDTH+1 cycles from start acceptance to the done pulse.
- Boundary conditions:
  - start while busy=1, or in FIN, is ignored; the pattern register is not reloaded.
  - start and rst both high: rst wins.
  - A pattern that equals the current q at every bit produces j=k=0 throughout.
  - q_fb is sampled only in DRIVE and CHECK; glitches in other states have no effect.
  - A start arriving in the IDLE cycle right after FIN is accepted normally (back-to-back runs).

Test Plan:
- Bench wiring: an external jk_ff is driven by j/k, with its q fed back to q_fb and its own rst tied to the bench rst.
- rst=1 for 2 cycles, then released -> j=k=0, busy=0, done=0, err_cnt=0, bit_idx=0.
- USE_TOGGLE=0, pattern=8'b1010_0110, start pulse -> q sequence 0,1,1,0,0,1,0,1; done after 25 cycles; err_cnt=0.
  - First bit (c=0, t=0): j=0, k=0.
  - Second bit (c=0, t=1): j=1, k=0.
  - Fourth bit (c=1, t=0): j=0, k=1.
- USE_TOGGLE=1, same pattern -> every bit change shows j=k=1 in APPLY; same q sequence; err_cnt=0.
- Bench forces q_fb=0 for the whole run, pattern=8'hFF -> err_cnt=8.
  - With CNT_W=2, err_cnt saturates at 3.
- start pulse again at bit_idx=3 of a running pattern=8'h0F -> ignored; run completes on 8'h0F; exactly one done pulse.
- rst asserted during APPLY of bit 5 -> next cycle all outputs at reset values, no done pulse; a new start then runs normally from bit 0.

Source files
------------

// File: rtl/jk_excitation_sequencer.sv
// Drives a jk_ff through a programmed q pattern using JK excitation,
// then reads q back and counts mismatches per run.
module jk_excitation_sequencer #(
  parameter int WIDTH      = 8,
  parameter int IDX_W      = 3,
  parameter int CNT_W      = 4,
  parameter int USE_TOGGLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic [IDX_W-1:0] bit_idx,
  output logic [CNT_W-1:0] err_cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    APPLY,
    CHECK,
    FIN
  } state_e;

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tgt;
  logic             diff;

  assign tgt  = pat_q[idx_q];
  assign diff = q_fb ^ tgt;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    err_d   = err_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = pattern;
          idx_d   = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        // equal current/target bits need no excitation at all
        if (diff) begin
          if (USE_TOGGLE != 0) begin
            j_d = 1'b1;
            k_d = 1'b1;
          end else begin
            j_d = tgt;
            k_d = ~tgt;
          end
        end
        state_d = APPLY;
      end
      APPLY: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (diff && (err_q != ERR_MAX)) begin
          err_d = err_q + CNT_W'(1);
        end
        if (idx_q == LAST) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = DRIVE;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign j       = j_q;
  assign k       = k_q;
  assign busy    = busy_q;
  assign bit_idx = idx_q;
  assign err_cnt = err_q;
  assign done    = done_q;

endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Bench: three sequencers (set/reset, toggle, 2-bit counter) each
// driving its own jk_ff, checked against a per-run trace model.
module tb_jk_excitation_sequencer;

  localparam int W   = 8;
  localparam int END = 3 * W + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic       force0;
  logic       glitch;
  bit         glitch_en;
  logic [2:0] ffq;
  logic [2:0] qfb;
  logic [2:0] j, k, busy, done;
  logic [2:0] idx0, idx1, idx2;
  logic [3:0] err0, err1;
  logic [1:0] err2;
  logic [2:0] idxa [3];
  logic [3:0] erra [3];

  int n_chk  = 0;
  int n_fail = 0;
  int done_seen = 0;

  // trace model state
  int off = 0;
  int lidx = 0;
  int lerr [3];
  bit mq [3];
  bit tj [0:2][1:END];
  bit tk [0:2][1:END];
  int terr [0:2][1:END];

  always #5 clk = ~clk;

  jk_excitation_sequencer #(.WIDTH(8), .IDX_W(3), .CNT_W(4), .USE_TOGGLE(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .q_fb(qfb[0]),
    .j(j[0]), .k(k[0]), .busy(busy[0]), .bit_idx(idx0), .err_cnt(err0),
    .done(done[0]));

  jk_excitation_sequencer #(.WIDTH(8), .IDX_W(3), .CNT_W(4), .USE_TOGGLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .q_fb(qfb[1]),
    .j(j[1]), .k(k[1]), .busy(busy[1]), .bit_idx(idx1), .err_cnt(err1),
    .done(done[1]));

  jk_excitation_sequencer #(.WIDTH(8), .IDX_W(3), .CNT_W(2), .USE_TOGGLE(0)) u2 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .q_fb(qfb[2]),
    .j(j[2]), .k(k[2]), .busy(busy[2]), .bit_idx(idx2), .err_cnt(err2),
    .done(done[2]));

  assign idxa[0] = idx0;
  assign idxa[1] = idx1;
  assign idxa[2] = idx2;
  assign erra[0] = err0;
  assign erra[1] = err1;
  assign erra[2] = {2'b00, err2};

  assign qfb = force0 ? 3'b000 : (ffq ^ {3{glitch}});

  // the external jk_ff instances
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) ffq[i] <= 1'b0;
      else begin
        case ({j[i], k[i]})
          2'b01:   ffq[i] <= 1'b0;
          2'b10:   ffq[i] <= 1'b1;
          2'b11:   ffq[i] <= ~ffq[i];
          default: ffq[i] <= ffq[i];
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit jkn(input bit q, input bit jj, input bit kk);
    case ({jj, kk})
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return !q;
      default: return q;
    endcase
  endfunction

  // whole-run expected trace from the excitation rules
  task automatic build(input int i, input logic [7:0] p, input bit frc);
    bit q, c, t, jj, kk;
    int e, emax, d;
    q = mq[i];
    e = 0;
    emax = (i == 2) ? 3 : 15;
    for (int b = 0; b < W; b++) begin
      t = p[b];
      c = frc ? 1'b0 : q;
      jj = 1'b0;
      kk = 1'b0;
      if (c != t) begin
        if (i == 1) begin
          jj = 1'b1;
          kk = 1'b1;
        end else begin
          jj = t;
          kk = !t;
        end
      end
      d = 3 * b + 1;
      tj[i][d] = 0; tk[i][d] = 0; terr[i][d] = e;
      tj[i][d+1] = jj; tk[i][d+1] = kk; terr[i][d+1] = e;
      tj[i][d+2] = 0; tk[i][d+2] = 0; terr[i][d+2] = e;
      q = jkn(q, jj, kk);
      c = frc ? 1'b0 : q;
      if (c != t && e < emax) e++;
    end
    tj[i][END] = 0;
    tk[i][END] = 0;
    terr[i][END] = e;
    mq[i] = q;
  endtask

  task automatic step();
    if (rst) begin
      off = 0;
      lidx = 0;
      for (int i = 0; i < 3; i++) begin
        mq[i] = 0;
        lerr[i] = 0;
      end
    end else if (off == 0) begin
      if (start === 1'b1) begin
        for (int i = 0; i < 3; i++) build(i, pattern, force0);
        off = 1;
      end
    end else if (off == END) begin
      off = 0;
      lidx = W - 1;
      for (int i = 0; i < 3; i++) lerr[i] = terr[i][END];
    end else begin
      off++;
    end
  endtask

  task automatic compare_all();
    logic [10:0] a, e;
    int b;
    for (int i = 0; i < 3; i++) begin
      a = {j[i], k[i], busy[i], done[i], idxa[i], erra[i]};
      if (off == 0) begin
        e = {4'b0000, 3'(lidx), 4'(lerr[i])};
      end else begin
        b = (off - 1) / 3;
        if (b > W - 1) b = W - 1;
        e = {tj[i][off], tk[i][off], 1'b1, (off == END),
             3'(b), 4'(terr[i][off])};
      end
      chk($sformatf("u%0d_jk_busy_done_idx_err", i), 32'(a), 32'(e));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      lerr[i] = 0;
      mq[i] = 0;
    end
    forever begin
      @(posedge clk);
      step();
    end
  end

  initial forever begin
    @(negedge clk);
    compare_all();
    if (done[0] === 1'b1) done_seen++;
  end

  // q_fb glitches only where the sequencer must not be sampling it
  initial begin
    glitch = 1'b0;
    forever begin
      @(negedge clk);
      if (glitch_en && (off == 0 || off == END || ((off - 1) % 3) == 1))
        glitch = 1'($urandom_range(0, 1));
      else
        glitch = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic run(input logic [7:0] p, input int extra_at,
                     input logic [7:0] xp, input int rst_at,
                     output int n, output logic [7:0] q0,
                     output logic [7:0] q1, output bit ab);
    ab = 0;
    q0 = '0;
    q1 = '0;
    pattern = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 60) begin
      if (done[0] === 1'b1) break;
      if (n % 3 == 0 && n <= 3 * W) begin
        q0[n/3-1] = ffq[0];
        q1[n/3-1] = ffq[1];
      end
      if (n == extra_at) begin
        start = 1'b1;
        pattern = xp;
      end
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        ab = 1;
        break;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (!ab) begin
      chk("done_within_budget", 32'(done[0]), 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    int n, ds, ex, ra, gap;
    logic [7:0] q0, q1;
    bit ab;

    rst = 1'b1;
    start = 1'b1;
    pattern = 8'hFF;
    force0 = 1'b0;
    glitch_en = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        32'({j[0], k[0], busy[0], done[0], idx0, err0}), 32'd0);

    run(8'b1010_0110, 0, 8'h00, 0, n, q0, q1, ab);
    chk("run1_latency", 32'(n), 32'd25);
    chk("run1_err_u0", 32'(err0), 32'd0);
    chk("run1_err_u1", 32'(err1), 32'd0);
    chk("run1_qseq_u0", 32'(q0), 32'hA6);
    chk("run1_qseq_u1", 32'(q1), 32'hA6);
    chk("bit0_jk_setreset", 32'({tj[0][2], tk[0][2]}), 32'b00);
    chk("bit1_jk_setreset", 32'({tj[0][5], tk[0][5]}), 32'b10);
    chk("bit3_jk_setreset", 32'({tj[0][11], tk[0][11]}), 32'b01);
    chk("bit3_jk_toggle", 32'({tj[1][11], tk[1][11]}), 32'b11);
    chk("bit1_jk_toggle", 32'({tj[1][5], tk[1][5]}), 32'b11);
    chk("bit4_jk_hold", 32'({tj[1][14], tk[1][14]}), 32'b00);

    force0 = 1'b1;
    @(negedge clk);
    run(8'hFF, 0, 8'h00, 0, n, q0, q1, ab);
    chk("forced_err_u0", 32'(err0), 32'd8);
    chk("forced_err_u1", 32'(err1), 32'd8);
    chk("forced_err_sat_u2", 32'(err2), 32'd3);
    force0 = 1'b0;
    @(negedge clk);

    ds = done_seen;
    run(8'h0F, 10, 8'hF0, 0, n, q0, q1, ab);
    chk("midrun_start_one_done", 32'(done_seen - ds), 32'd1);
    chk("midrun_start_qseq", 32'(q0), 32'h0F);
    chk("midrun_start_err", 32'(err0), 32'd0);

    ds = done_seen;
    run(8'h3C, 0, 8'h00, 17, n, q0, q1, ab);
    chk("rst_apply_aborted", 32'(ab), 32'd1);
    chk("rst_apply_outputs",
        32'({j[0], k[0], busy[0], done[0], idx0, err0}), 32'd0);
    @(negedge clk);
    chk("rst_apply_no_done", 32'(done_seen - ds), 32'd0);
    run(8'h5A, 0, 8'h00, 0, n, q0, q1, ab);
    chk("after_rst_latency", 32'(n), 32'd25);
    chk("after_rst_qseq", 32'(q0), 32'h5A);
    chk("after_rst_err", 32'(err0), 32'd0);

    // back-to-back: start in the IDLE cycle right after FIN
    run(8'hC3, 0, 8'h00, 0, n, q0, q1, ab);
    chk("b2b_latency", 32'(n), 32'd25);
    chk("b2b_qseq", 32'(q1), 32'hC3);

    glitch_en = 1;
    for (int r = 0; r < 24; r++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      force0 = ($urandom_range(0, 4) == 0);
      ex = ($urandom_range(0, 1) == 1) ? $urandom_range(2, END) : 0;
      ra = ($urandom_range(0, 7) == 0) ? $urandom_range(1, END) : 0;
      run(8'($urandom), ex, 8'($urandom), ra, n, q0, q1, ab);
      if (!ab && !force0) begin
        chk("rand_err_u0", 32'(err0), 32'd0);
        chk("rand_err_u1", 32'(err1), 32'd0);
      end
      force0 = 1'b0;
    end
    glitch_en = 0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
